instr_loader: RTL and testbench

//  Byte-stream bootloader that writes 9-bit instruction words into a writable instruction memory.
//  The fetch side (pc_in -> format/opcode/sign/operand/immediate) reads the memory this block fills.

---
 rtl/instr_loader.sv | 186 ++++++++++++++++++
 tb/tb_instr_loader.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_loader.sv
// Byte-stream bootloader: parses a length-prefixed, checksummed image and writes
// 9-bit instruction words into instruction memory while holding the CPU in reset.
module instr_loader #(
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 256,
    parameter int BASE   = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [8:0]        wr_data,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [15:0]       words_written
);
    typedef enum logic [3:0] {
        IDLE, LEN_HI, LEN_LO, INS_HI, INS_LO, WRITE, CHECK, DONE, ERR
    } state_t;

    localparam logic [ADDR_W-1:0] BASE_A  = ADDR_W'(BASE);
    localparam logic [16:0]       DEPTH_L = 17'(DEPTH);

    state_t              state_q, state_d;
    logic                rx_ready_q, rx_ready_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [8:0]          wr_data_q, wr_data_d;
    logic                cpu_hold_q, cpu_hold_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [1:0]          err_code_q, err_code_d;
    logic [15:0]         words_q, words_d;
    logic [7:0]          sum_q, sum_d;
    logic [15:0]         len_q, len_d;
    logic                hi_q, hi_d;

    logic                accept;
    logic [15:0]         len_rx;
    logic [15:0]         words_inc;

    assign accept    = rx_valid && rx_ready_q;
    assign len_rx    = {len_q[15:8], rx_data};
    assign words_inc = words_q + 16'd1;

    always_comb begin
        state_d    = state_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        err_code_d = err_code_q;
        words_d    = words_q;
        sum_d      = sum_q;
        len_d      = len_q;
        hi_d       = hi_q;

        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d    = LEN_HI;
                    err_code_d = 2'd0;
                    words_d    = 16'd0;
                    sum_d      = 8'd0;
                end
            end
            LEN_HI: begin
                if (accept) begin
                    len_d[15:8] = rx_data;
                    sum_d       = sum_q + rx_data;
                    state_d     = LEN_LO;
                end
            end
            LEN_LO: begin
                if (accept) begin
                    len_d = len_rx;
                    sum_d = sum_q + rx_data;
                    if ({1'b0, len_rx} > DEPTH_L) begin
                        state_d    = ERR;
                        err_code_d = 2'd1;
                    end else if (len_rx == 16'd0) begin
                        state_d = CHECK;
                    end else begin
                        state_d = INS_HI;
                    end
                end
            end
            INS_HI: begin
                if (accept) begin
                    sum_d = sum_q + rx_data;
                    if (rx_data[7:1] != 7'd0) begin
                        state_d    = ERR;
                        err_code_d = 2'd2;
                    end else begin
                        hi_d    = rx_data[0];
                        state_d = INS_LO;
                    end
                end
            end
            INS_LO: begin
                if (accept) begin
                    sum_d     = sum_q + rx_data;
                    wr_data_d = {hi_q, rx_data};
                    wr_addr_d = BASE_A + ADDR_W'(words_q);
                    state_d   = WRITE;
                end
            end
            WRITE: begin
                words_d = words_inc;
                state_d = (words_inc == len_q) ? CHECK : INS_HI;
            end
            CHECK: begin
                if (accept) begin
                    if (rx_data == sum_q) begin
                        state_d = DONE;
                    end else begin
                        state_d    = ERR;
                        err_code_d = 2'd3;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Status outputs are registered from the next state so they line up with it.
        rx_ready_d = (state_d inside {LEN_HI, LEN_LO, INS_HI, INS_LO, CHECK});
        wr_en_d    = (state_d == WRITE);
        busy_d     = !(state_d inside {IDLE, DONE, ERR});
        done_d     = (state_d == DONE);
        err_d      = (state_d == ERR);
        cpu_hold_d = (state_d != DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            rx_ready_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= 9'd0;
            cpu_hold_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= 2'd0;
            words_q    <= 16'd0;
            sum_q      <= 8'd0;
        end else begin
            state_q    <= state_d;
            rx_ready_q <= rx_ready_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            cpu_hold_q <= cpu_hold_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            words_q    <= words_d;
            sum_q      <= sum_d;
        end
    end

    always_ff @(posedge clk) begin
        len_q <= len_d;
        hi_q  <= hi_d;
    end

    assign rx_ready      = rx_ready_q;
    assign wr_en         = wr_en_q;
    assign wr_addr       = wr_addr_q;
    assign wr_data       = wr_data_q;
    assign cpu_hold      = cpu_hold_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign err_code      = err_code_q;
    assign words_written = words_q;

endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader: an image-level reference model queues the
// expected writes and final status; a negedge monitor pops and compares writes.
module tb_instr_loader;
    localparam int ADDR_W = 16;
    localparam int DEPTH  = 256;
    localparam int BASE   = 0;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [8:0]        wr_data;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              err;
    logic [1:0]        err_code;
    logic [15:0]       words_written;

    instr_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE(BASE)) dut (
        .clk(clk), .reset(reset), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err), .err_code(err_code),
        .words_written(words_written)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_writes = 0;

    logic [7:0]  img[$];
    logic [15:0] exp_addr[$];
    logic [8:0]  exp_data[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Write monitor: every strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            n_writes++;
            if (exp_addr.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got addr=%0h data=%0h expected no write", wr_addr, wr_data);
            end else begin
                check("wr_addr", 32'(wr_addr), 32'(exp_addr.pop_front()));
                check("wr_data", 32'(wr_data), 32'(exp_data.pop_front()));
            end
        end
    end

    // Reference model: interprets the image bytes directly.
    task automatic run_model(output int consumed, output bit ok, output int code, output int words);
        int n;
        int s;
        ok = 1'b0; code = 0; words = 0;
        n = int'(img[0]) * 256 + int'(img[1]);
        s = int'(img[0]) + int'(img[1]);
        consumed = 2;
        if (n > DEPTH) begin
            code = 1;
            return;
        end
        for (int i = 0; i < n; i++) begin
            consumed++;
            s += int'(img[2 + 2*i]);
            if (img[2 + 2*i] > 8'd1) begin
                code = 2;
                return;
            end
            consumed++;
            s += int'(img[3 + 2*i]);
            exp_addr.push_back(16'((BASE + i) % 65536));
            exp_data.push_back({img[2 + 2*i][0], img[3 + 2*i]});
            words++;
        end
        consumed++;
        if (int'(img[2 + 2*n]) == (s % 256)) ok = 1'b1;
        else code = 3;
    endtask

    task automatic gen_image(input int n, input bit bad_pad, input bit bad_ck);
        logic [7:0] hi, lo, ck;
        int badk;
        img.delete();
        img.push_back(8'(n >> 8));
        img.push_back(8'(n));
        if (n > DEPTH) return;
        badk = bad_pad ? int'($urandom_range(0, n - 1)) : -1;
        for (int k = 0; k < n; k++) begin
            hi = {7'd0, 1'($urandom)};
            if (k == badk) hi[7:1] = 7'($urandom_range(1, 127));
            lo = 8'($urandom);
            img.push_back(hi);
            img.push_back(lo);
        end
        ck = 8'd0;
        foreach (img[i]) ck = ck + img[i];
        if (bad_ck) ck = ck ^ (8'd1 << $urandom_range(0, 7));
        img.push_back(ck);
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit sent = 1'b0;
        int guard = 0;
        while (!sent) begin
            @(negedge clk);
            rx_data  = b;
            rx_valid = ($urandom_range(0, 3) != 0);
            if (rx_valid && rx_ready) sent = 1'b1;
            guard++;
            if (!sent && guard > 200) begin
                n_checks++;
                n_fail++;
                $display("FAIL rx_timeout: got rx_ready=%0b expected 1 within 200 cycles", rx_ready);
                sent = 1'b1;
            end
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        rx_valid = 1'b0;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_rx_ready"}, 32'(rx_ready), 0);
        check({tag, "_wr_en"}, 32'(wr_en), 0);
        check({tag, "_wr_addr"}, 32'(wr_addr), 0);
        check({tag, "_wr_data"}, 32'(wr_data), 0);
        check({tag, "_cpu_hold"}, 32'(cpu_hold), 1);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_err"}, 32'(err), 0);
        check({tag, "_err_code"}, 32'(err_code), 0);
        check({tag, "_words"}, 32'(words_written), 0);
    endtask

    task automatic run_load(input string tag);
        int consumed, code, words, t, w0;
        bit ok;
        run_model(consumed, ok, code, words);
        w0 = n_writes;
        pulse_start();
        check({tag, "_busy_start"}, 32'(busy), 1);
        check({tag, "_hold_start"}, 32'(cpu_hold), 1);
        check({tag, "_done_clr"}, 32'(done), 0);
        check({tag, "_err_clr"}, 32'(err), 0);
        for (int i = 0; i < consumed; i++) send_byte(img[i]);
        @(negedge clk);
        rx_valid = 1'b0;
        t = 0;
        while (busy && t < 20) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_busy_end"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 32'(ok));
        check({tag, "_err"}, 32'(err), 32'(!ok));
        check({tag, "_err_code"}, 32'(err_code), 32'(code));
        check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'(!ok));
        check({tag, "_words"}, 32'(words_written), 32'(words));
        check({tag, "_nwrites"}, 32'(n_writes - w0), 32'(words));
        check({tag, "_pending"}, 32'(exp_addr.size()), 0);
    endtask

    task automatic set_img(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                           input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5,
                           input logic [7:0] b6, input int len);
        logic [7:0] all[7];
        all[0] = b0; all[1] = b1; all[2] = b2; all[3] = b3;
        all[4] = b4; all[5] = b5; all[6] = b6;
        img.delete();
        for (int i = 0; i < len; i++) img.push_back(all[i]);
    endtask

    initial begin
        int kind, n, t, w0;
        reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'd0;
        repeat (3) @(negedge clk);
        check_reset("reset");
        reset = 1'b0;

        set_img(8'h00, 8'h02, 8'h00, 8'h00, 8'h01, 8'h78, 8'h7B, 7);
        run_load("t1_good");
        set_img(8'h00, 8'h02, 8'h00, 8'h00, 8'h01, 8'h78, 8'h7C, 7);
        run_load("t2_badck");
        set_img(8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 2);
        run_load("t3_len");
        set_img(8'h00, 8'h01, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 3);
        run_load("t4_pad");
        set_img(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 3);
        run_load("t5_empty");
        gen_image(DEPTH, 1'b0, 1'b0);
        run_load("full_depth");

        for (int it = 0; it < 25; it++) begin
            kind = int'($urandom_range(0, 9));
            n = int'($urandom_range(1, 6));
            case (kind)
                0: gen_image(int'($urandom_range(DEPTH + 1, 65535)), 1'b0, 1'b0);
                1: gen_image(n, 1'b1, 1'b0);
                2: gen_image(n, 1'b0, 1'b1);
                3: gen_image(0, 1'b0, 1'b0);
                default: gen_image(n, 1'b0, 1'b0);
            endcase
            run_load("rand");
        end

        // Abort after the first of three words; start mid-load must be ignored.
        gen_image(3, 1'b0, 1'b0);
        exp_addr.push_back(16'(BASE));
        exp_data.push_back({img[2][0], img[3]});
        w0 = n_writes;
        pulse_start();
        send_byte(img[0]);
        pulse_start();
        for (int i = 1; i < 4; i++) send_byte(img[i]);
        @(negedge clk);
        rx_valid = 1'b0;
        t = 0;
        while (words_written != 16'd1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("t6_words_before_reset", 32'(words_written), 1);
        reset = 1'b1;
        @(negedge clk);
        check_reset("t6_reset");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("t6_nwrites", 32'(n_writes - w0), 1);
        check("t6_pending", 32'(exp_addr.size()), 0);
        gen_image(3, 1'b0, 1'b0);
        run_load("t6_reload");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
